// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and the decode-stage data request.
// A registered request is issued with valid/ready, and the response is steered back to its owner.

module mem_port_arbiter_lane #(
  parameter int LANE = 0
) (
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  input  logic [2:0]  woff_i,
  input  logic [2:0]  roff_i,
  input  logic [1:0]  len_i,
  output logic [7:0]  wbyte_o,
  output logic [7:0]  rbyte_o,
  output logic        strb_o
);
  localparam logic [3:0] L = 4'(LANE);

  logic [3:0] wdist, rpos, size;
  logic [2:0] wsel, rsel;
  logic       above;

  always_comb begin
    above   = (L >= {1'b0, woff_i});
    wdist   = L - {1'b0, woff_i};
    rpos    = L + {1'b0, roff_i};
    size    = 4'd1 << len_i;
    wsel    = wdist[2:0];
    rsel    = rpos[2:0];
    wbyte_o = above ? wdata_i[{wsel, 3'b000} +: 8] : 8'h00;
    strb_o  = above && (wdist < size);
    // source bytes beyond the top lane shift in as zero (no extension)
    rbyte_o = rpos[3] ? 8'h00 : rdata_i[{rsel, 3'b000} +: 8];
  end
endmodule

module mem_port_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int STARVE_N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_valid_i,
  input  logic              d_wen_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [1:0]        d_wlen_i,
  output logic              d_ready_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [7:0]        mem_wstrb_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);
  localparam int NB = 8;
  localparam int SW = $clog2(STARVE_N + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_N);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                own_d_q, own_d_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]       wstrb_q, wstrb_d;

  logic [NB-1:0][7:0]  wbyte, rbyte;
  logic [NB-1:0]       strb;

  // write lanes align the incoming request; read lanes align the response of the latched owner
  for (genvar g = 0; g < NB; g++) begin : g_lane
    mem_port_arbiter_lane #(.LANE(g)) u_lane (
      .wdata_i (d_wdata_i),
      .rdata_i (mem_rdata_i),
      .woff_i  (d_addr_i[2:0]),
      .roff_i  (addr_q[2:0]),
      .len_i   (d_wlen_i),
      .wbyte_o (wbyte[g]),
      .rbyte_o (rbyte[g]),
      .strb_o  (strb[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    own_d_d     = own_d_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    if_ready_o  = 1'b0;
    d_ready_o   = 1'b0;
    if_rvalid_o = 1'b0;
    d_rvalid_o  = 1'b0;
    mem_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req_valid_i && !(if_req_valid_i && starve_q == STARVE_MAX)) begin
          d_ready_o = 1'b1;
          own_d_d   = 1'b1;
          wen_d     = d_wen_i;
          addr_d    = d_addr_i;
          wdata_d   = wbyte;
          wstrb_d   = d_wen_i ? strb : '0;
          state_d   = ISSUE;
          if (if_req_valid_i && starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
        end else if (if_req_valid_i) begin
          if_ready_o = 1'b1;
          own_d_d    = 1'b0;
          wen_d      = 1'b0;
          addr_d     = if_addr_i;
          wdata_d    = '0;
          wstrb_d    = '0;
          starve_d   = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        mem_valid_o = 1'b1;
        if (mem_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          d_rvalid_o  = own_d_q;
          if_rvalid_o = !own_d_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      own_d_q  <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      own_d_q  <= own_d_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

  assign mem_wen_o   = wen_q;
  assign mem_addr_o  = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;

  // response data is only driven during the owner's rvalid pulse
  assign if_rdata_o = !if_rvalid_o ? 32'd0 :
                      (addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0]);
  assign d_rdata_o  = d_rvalid_o ? rbyte : '0;

  assign stall_o = (d_req_valid_i & ~d_ready_o) |
                   (own_d_q & (state_q != IDLE) & ~d_rvalid_o);
endmodule
